// File: rtl/melody_recorder.sv
// Records live key presses and turns each one into a 6-bit note code in a packed melody buffer.
// Latency: keys and controls pass through 2-flop synchronizers. A code is written on the edge after the release (or stop) is seen.
// Backpressure: none. Recording ends by itself when the buffer fills, and the melody is held until the next rec_start.
// Ports: clk/reset (async active-low); note_keys[6]=do..[0]=si; oct_hi/oct_lo octave select;
//        rec_start/rec_stop level controls (rising edge acts); recording/full status;
//        wr_strobe/wr_code per written code; melody (entry i at [i*6+5 -: 6]) and melody_len.
module melody_recorder #(
    parameter int DEPTH     = 333,
    parameter int TICK_DIV  = 100000,
    parameter int SHORT_MAX = 150,
    parameter int LONG_MIN  = 400,
    parameter int REST_MIN  = 300
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [6:0]                 note_keys,
    input  logic                       oct_hi,
    input  logic                       oct_lo,
    input  logic                       rec_start,
    input  logic                       rec_stop,
    output logic                       recording,
    output logic                       full,
    output logic                       wr_strobe,
    output logic [5:0]                 wr_code,
    output logic [DEPTH*6-1:0]         melody,
    output logic [$clog2(DEPTH+1)-1:0] melody_len
);
    localparam int          LW        = $clog2(DEPTH + 1);
    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);
    localparam logic [15:0] SHORT_T   = 16'(SHORT_MAX);
    localparam logic [15:0] LONG_T    = 16'(LONG_MIN);
    localparam logic [15:0] REST_T    = 16'(REST_MIN);

    typedef enum logic [1:0] {IDLE, ARMED, PRESS, GAP} state_t;
    typedef enum logic [1:0] {OCT_MID, OCT_LOW, OCT_HIGH} oct_t;

    state_t      state;
    oct_t        oct_q, key_oct;
    logic [10:0] sync1, sync2;
    logic [6:0]  keys_s, mask_q;
    logic        hi_s, lo_s, start_s, stop_s, start_q, stop_q;
    logic        start_edge, stop_edge;
    logic [31:0] presc;
    logic        tick;
    logic [15:0] hold_cnt, gap_cnt;
    logic [2:0]  note_q, key_note;
    logic        blocked, press_ok, multi, rest_due;
    logic        wr_go, full_hit;
    logic [5:0]  wr_val;

    // Offsets: octave picks the block of 21, duration picks 0/7/14 inside it.
    function automatic logic [5:0] encode(input logic [2:0] n, input oct_t oct, input logic [15:0] hold);
        logic [5:0] base, dur;
        base = (oct == OCT_LOW) ? 6'd21 : (oct == OCT_HIGH) ? 6'd42 : 6'd0;
        if (hold < SHORT_T)       dur = 6'd14;
        else if (hold >= LONG_T)  dur = 6'd7;
        else                      dur = 6'd0;
        return base + dur + {3'b000, n};
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {note_keys, oct_hi, oct_lo, rec_start, rec_stop};
            sync2 <= sync1;
        end
    end

    assign keys_s     = sync2[10:4];
    assign hi_s       = sync2[3];
    assign lo_s       = sync2[2];
    assign start_s    = sync2[1];
    assign stop_s     = sync2[0];
    assign start_edge = start_s & ~start_q;
    assign stop_edge  = stop_s & ~stop_q;
    assign tick       = (presc == TICK_LAST);
    assign recording  = (state != IDLE);

    // A chord blocks presses until every key is up again.
    assign multi    = (keys_s != 7'd0) && !$onehot(keys_s);
    assign press_ok = $onehot(keys_s) && !blocked;
    assign rest_due = (state == GAP) && tick && (gap_cnt == REST_T - 16'd1);

    always_comb begin
        key_note = 3'd0;
        for (int i = 0; i < 7; i++)
            if (keys_s[i]) key_note = 3'(7 - i);
        key_oct = OCT_MID;
        if (hi_s && !lo_s)      key_oct = OCT_HIGH;
        else if (lo_s && !hi_s) key_oct = OCT_LOW;
    end

    // Stop takes priority over a maturing rest; in PRESS it flushes the held note.
    always_comb begin
        wr_go  = 1'b0;
        wr_val = 6'd0;
        if (state == PRESS && (stop_edge || (keys_s & mask_q) == 7'd0)) begin
            wr_go  = 1'b1;
            wr_val = encode(note_q, oct_q, hold_cnt);
        end else if (state == GAP && !stop_edge && rest_due) begin
            wr_go  = 1'b1;
        end
    end

    assign full_hit = wr_go && (melody_len == LW'(DEPTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            presc      <= '0;
            hold_cnt   <= '0;
            gap_cnt    <= '0;
            note_q     <= '0;
            oct_q      <= OCT_MID;
            mask_q     <= '0;
            blocked    <= 1'b0;
            full       <= 1'b0;
            wr_strobe  <= 1'b0;
            wr_code    <= '0;
            melody     <= '0;
            melody_len <= '0;
        end else begin
            start_q   <= start_s;
            stop_q    <= stop_s;
            wr_strobe <= 1'b0;
            presc     <= tick ? 32'd0 : presc + 32'd1;

            if (state == ARMED || state == GAP) begin
                if (keys_s == 7'd0) blocked <= 1'b0;
                else if (multi)     blocked <= 1'b1;
            end

            if (wr_go) begin
                for (int i = 0; i < DEPTH; i++)
                    if (melody_len == LW'(i)) melody[i*6 +: 6] <= wr_val;
                melody_len <= melody_len + LW'(1);
                wr_strobe  <= 1'b1;
                wr_code    <= wr_val;
            end

            case (state)
                IDLE: begin
                    if (start_edge && !stop_edge) begin
                        state      <= ARMED;
                        melody_len <= '0;
                        melody     <= '0;
                        full       <= 1'b0;
                        blocked    <= 1'b0;
                    end
                end
                ARMED, GAP: begin
                    if (stop_edge) begin
                        state <= IDLE;
                    end else if (full_hit) begin
                        full  <= 1'b1;
                        state <= IDLE;
                    end else if (press_ok) begin
                        state    <= PRESS;
                        note_q   <= key_note;
                        oct_q    <= key_oct;
                        mask_q   <= keys_s;
                        hold_cnt <= '0;
                        presc    <= '0;
                    end else if (state == GAP && tick) begin
                        if (rest_due)                gap_cnt <= '0;
                        else if (gap_cnt != 16'hFFFF) gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                PRESS: begin
                    if (wr_go) begin
                        if (full_hit) begin
                            full  <= 1'b1;
                            state <= IDLE;
                        end else if (stop_edge) begin
                            state <= IDLE;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= '0;
                            presc   <= '0;
                        end
                    end else if (tick && hold_cnt != 16'hFFFF) begin
                        hold_cnt <= hold_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_melody_recorder.sv
module tb_melody_recorder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  note_keys = '0;
    logic        oct_hi = 1'b0, oct_lo = 1'b0, rec_start = 1'b0, rec_stop = 1'b0;
    logic        recording, full, wr_strobe;
    logic [5:0]  wr_code;
    logic [23:0] melody;
    logic [2:0]  melody_len;

    int checks = 0;
    int errors = 0;
    logic [5:0] codes[$];

    localparam logic [6:0] K_DO = 7'b1000000, K_RE = 7'b0100000, K_MI = 7'b0010000,
                           K_FA = 7'b0001000, K_SOL = 7'b0000100, K_LA = 7'b0000010,
                           K_SI = 7'b0000001;

    melody_recorder #(.DEPTH(4), .TICK_DIV(4), .SHORT_MAX(4), .LONG_MIN(8), .REST_MIN(6)) dut (
        .clk(clk), .reset(reset), .note_keys(note_keys), .oct_hi(oct_hi), .oct_lo(oct_lo),
        .rec_start(rec_start), .rec_stop(rec_stop), .recording(recording), .full(full),
        .wr_strobe(wr_strobe), .wr_code(wr_code), .melody(melody), .melody_len(melody_len)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (wr_strobe === 1'b1) codes.push_back(wr_code);

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        rec_start = 1'b1; idle(4); rec_start = 1'b0; idle(4);
    endtask

    task automatic pulse_stop();
        rec_stop = 1'b1; idle(4); rec_stop = 1'b0; idle(4);
    endtask

    // Hold one key pattern for a number of ticks (4 clocks each), then release.
    task automatic hold_key(input logic [6:0] k, input int ticks);
        note_keys = k; idle(ticks * 4); note_keys = '0;
    endtask

    task automatic test_reset();
        idle(3);
        checks++; if (recording !== 1'b0) begin errors++; $display("FAIL reset_recording got=%b exp=0", recording); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got=%b exp=0", wr_strobe); end
        checks++; if (melody !== 24'd0) begin errors++; $display("FAIL reset_melody got=%h exp=0", melody); end
        checks++; if (melody_len !== 3'd0) begin errors++; $display("FAIL reset_len got=%0d exp=0", melody_len); end
        reset = 1'b1;
        idle(3);
    endtask

    task automatic test_sixteenth();
        pulse_start();
        checks++; if (recording !== 1'b1) begin errors++; $display("FAIL start_recording got=%b exp=1", recording); end
        codes.delete();
        hold_key(K_DO, 3);
        idle(8);
        checks++; if (codes.size() != 1) begin errors++; $display("FAIL t1_count got=%0d exp=1", codes.size()); end
        checks++; if (codes.size() < 1 || codes[0] !== 6'd15) begin errors++; $display("FAIL t1_code got=%0d exp=15", codes.size() ? codes[0] : 6'h3F); end
        checks++; if (melody_len !== 3'd1) begin errors++; $display("FAIL t1_len got=%0d exp=1", melody_len); end
        checks++; if (melody[5:0] !== 6'd15) begin errors++; $display("FAIL t1_mem0 got=%0d exp=15", melody[5:0]); end
    endtask

    task automatic test_octaves();
        logic [5:0] exp_c [2];
        exp_c[0] = 6'd54; exp_c[1] = 6'd23;
        codes.delete();
        oct_hi = 1'b1; idle(4);
        hold_key(K_SOL, 10);
        idle(8);
        oct_hi = 1'b0; oct_lo = 1'b1; idle(4);
        hold_key(K_RE, 5);
        idle(8);
        oct_lo = 1'b0;
        checks++; if (codes.size() != 2) begin errors++; $display("FAIL t2_count got=%0d exp=2", codes.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (codes.size() <= i || codes[i] !== exp_c[i]) begin
                errors++; $display("FAIL t2_code%0d got=%0d exp=%0d", i, codes.size() > i ? codes[i] : 6'h3F, exp_c[i]);
            end
        end
        checks++; if (melody_len !== 3'd3) begin errors++; $display("FAIL t2_len got=%0d exp=3", melody_len); end
        checks++; if (melody[17:6] !== {6'd23, 6'd54}) begin errors++; $display("FAIL t2_mem got=%h exp=%h", melody[17:6], {6'd23, 6'd54}); end
        pulse_stop();
        checks++; if (recording !== 1'b0) begin errors++; $display("FAIL t2_stop_recording got=%b exp=0", recording); end
        checks++; if (melody_len !== 3'd3) begin errors++; $display("FAIL t2_stop_len got=%0d exp=3", melody_len); end
    endtask

    task automatic test_rests_full();
        logic [5:0] exp_c [4];
        exp_c[0] = 6'd17; exp_c[1] = 6'd0; exp_c[2] = 6'd0; exp_c[3] = 6'd18;
        pulse_start();
        checks++; if (melody_len !== 3'd0) begin errors++; $display("FAIL t3_start_len got=%0d exp=0", melody_len); end
        idle(40);
        codes.delete();
        hold_key(K_MI, 2);
        idle(52);
        hold_key(K_FA, 2);
        idle(10);
        checks++; if (codes.size() != 4) begin errors++; $display("FAIL t3_count got=%0d exp=4", codes.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (codes.size() <= i || codes[i] !== exp_c[i]) begin
                errors++; $display("FAIL t3_code%0d got=%0d exp=%0d", i, codes.size() > i ? codes[i] : 6'h3F, exp_c[i]);
            end
        end
        checks++; if (melody_len !== 3'd4) begin errors++; $display("FAIL t3_len got=%0d exp=4", melody_len); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL t3_full got=%b exp=1", full); end
        checks++; if (recording !== 1'b0) begin errors++; $display("FAIL t3_recording got=%b exp=0", recording); end
        // After filling, key presses are ignored and the melody is retained.
        hold_key(K_SI, 3);
        idle(8);
        checks++; if (melody !== {6'd18, 6'd0, 6'd0, 6'd17}) begin errors++; $display("FAIL t3_melody got=%h exp=%h", melody, {6'd18, 6'd0, 6'd0, 6'd17}); end
        checks++; if (codes.size() != 4) begin errors++; $display("FAIL t3_post_full_count got=%0d exp=4", codes.size()); end
    endtask

    task automatic test_chord();
        pulse_start();
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL t4_full_cleared got=%b exp=0", full); end
        checks++; if (melody !== 24'd0) begin errors++; $display("FAIL t4_melody_cleared got=%h exp=0", melody); end
        codes.delete();
        hold_key(K_DO | K_RE, 10);
        idle(8);
        pulse_stop();
        checks++; if (codes.size() != 0) begin errors++; $display("FAIL t4_count got=%0d exp=0", codes.size()); end
        checks++; if (melody_len !== 3'd0) begin errors++; $display("FAIL t4_len got=%0d exp=0", melody_len); end
        checks++; if (recording !== 1'b0) begin errors++; $display("FAIL t4_recording got=%b exp=0", recording); end
    endtask

    task automatic test_stop_mid_hold();
        pulse_start();
        codes.delete();
        note_keys = K_LA;
        idle(40);
        pulse_stop();
        note_keys = '0;
        idle(10);
        checks++; if (codes.size() != 1) begin errors++; $display("FAIL t5_count got=%0d exp=1", codes.size()); end
        checks++; if (codes.size() < 1 || codes[0] !== 6'd13) begin errors++; $display("FAIL t5_code got=%0d exp=13", codes.size() ? codes[0] : 6'h3F); end
        checks++; if (melody_len !== 3'd1) begin errors++; $display("FAIL t5_len got=%0d exp=1", melody_len); end
        checks++; if (recording !== 1'b0) begin errors++; $display("FAIL t5_recording got=%b exp=0", recording); end
    endtask

    task automatic test_reset_mid_press();
        pulse_start();
        hold_key(K_DO, 3);
        idle(8);
        checks++; if (melody[5:0] !== 6'd15) begin errors++; $display("FAIL t6_pre_mem0 got=%0d exp=15", melody[5:0]); end
        note_keys = K_SI;
        idle(20);
        reset = 1'b0;
        #1;
        checks++; if (recording !== 1'b0) begin errors++; $display("FAIL t6_recording got=%b exp=0", recording); end
        checks++; if (melody_len !== 3'd0) begin errors++; $display("FAIL t6_len got=%0d exp=0", melody_len); end
        checks++; if (melody !== 24'd0) begin errors++; $display("FAIL t6_melody got=%h exp=0", melody); end
        codes.delete();
        idle(3);
        reset = 1'b1;
        idle(40);
        note_keys = '0;
        idle(20);
        checks++; if (codes.size() != 0) begin errors++; $display("FAIL t6_no_strobe got=%0d exp=0", codes.size()); end
    endtask

    initial begin
        test_reset();
        test_sixteenth();
        test_octaves();
        test_rests_full();
        test_chord();
        test_stop_mid_hold();
        test_reset_mid_press();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
